conv_mac4x4: RTL and testbench
==============================

// Module: conv_mac4x4
// PURPOSE
//   Signed 4x4 dot-product engine: one 4x4 data window times one 4x4 kernel.
//   Produces the sum of the 16 element-wise products as a single partial sum.
//   Sits inside the CONV top level. Two instances (overlapping windows) each
//   yield one output-pixel partial sum per cycle; the top accumulates over channels.
// PARAMETERS
//   LEN_IN   8   width of each signed data/kernel element
//   LEN_OUT  25  width of the signed result; must be >= 2*LEN_IN+4
// PORTS
//   clk            in   1        clock; all state updates on posedge
//   rst            in   1        synchronous, active-high reset
//   in_valid       in   1        data/kernel inputs valid this cycle
//   data00..data33 in   LEN_IN   signed window element, row r, column c (dataRC)
//   kernel00..33   in   LEN_IN   signed kernel element kernelRC, same indexing
//   conv_out       out  LEN_OUT  signed sum(dataRC*kernelRC), r,c in 0..3
//   out_valid      out  1        conv_out holds a fresh result
// BEHAVIOUR
//   - Clock is clk; reset is synchronous and active-high (rst).
//   - Reset: conv_out=0, out_valid=0, all internal pipeline regs cleared.
//   - Each product is full precision: 2*LEN_IN signed bits.
//   - Products are summed in a balanced tree: 4 row sums of 2*LEN_IN+2 bits,
//     then 1 total of 2*LEN_IN+4 bits, sign-extended to LEN_OUT.
//   - No overflow is possible. Range is 16*(-128*127) .. 16*16384 = -260096..262144.
//   - Default latency is 1 cycle.
//     - Inputs sampled at edge N with in_valid=1 give conv_out/out_valid=1 after edge N.
//   - in_valid=0 at an edge:
//     - out_valid goes to 0 after that edge.
//     - conv_out holds its last value; the output register is not loaded.
//   - Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
//   - rst asserted mid-stream:
//     - Every in-flight result is discarded.
//     - out_valid=0 on the cycle after rst is sampled.
//   - rst has priority over in_valid at the same edge.
//   - Operands are two's-complement. -128*-128 = +16384 must be exact.
// CONFIGURATION
//   CONV_PIPE2_EN defined:
//     - Adds a register stage after the four row sums.
//     - Latency becomes 2 cycles; in_valid is delayed through a matching 2-deep valid shift.
//     - Throughput remains 1/cycle.
//     - rst clears both stages.
//   CONV_PIPE2_EN undefined:
//     - Single output register stage, latency 1.
//   Numerical results are identical in both builds.
// STRUCTURE
//   - Shared package conv_pkg:
//     - LEN_IN=8, LEN_OUT=25, KSIZE=4 constants.
//     - typedef elem_t (signed [LEN_IN-1:0]).
//     - typedef acc_t (signed [LEN_OUT-1:0]).
//   - Sub-module conv_dot4:
//     - Combinational 4-element signed dot product for one row.
//     - 4 instances, one per row; the top adds the 4 row sums and registers.
// TESTING
//   1. All data=1, all kernels=1, in_valid=1 -> conv_out=16, out_valid=1 after latency.
//   2. All data=-128, all kernels=-128 -> conv_out=262144 (max positive).
//   3. All data=-128, all kernels=127 -> conv_out=-260096 (min).
//      Checks sign extension to 25 bits.
//   4. data=1..16 row-major, kernel=identity diagonal (k00=k11=k22=k33=1, rest 0)
//      -> conv_out=1+6+11+16=34.
//   5. Random vectors streamed back-to-back for 1000 cycles vs a software model
//      -> every result matches with exact latency.
//      Then drop in_valid -> out_valid=0 and conv_out held.
//   6. rst pulsed while valid results are in flight -> conv_out=0, out_valid=0 next cycle.
//      The first post-reset vector produces its correct result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and element/accumulator types for the 4x4 convolution MAC.
package conv_pkg;
    localparam int LEN_IN  = 8;
    localparam int LEN_OUT = 25;
    localparam int KSIZE   = 4;

    typedef logic signed [LEN_IN-1:0]  elem_t;
    typedef logic signed [LEN_OUT-1:0] acc_t;
endpackage

// File: rtl/conv_dot4.sv
// Combinational signed 4-element dot product for one window row.
module conv_dot4 #(
    parameter int LEN_IN = 8
) (
    input  logic signed [LEN_IN-1:0]   a0,
    input  logic signed [LEN_IN-1:0]   a1,
    input  logic signed [LEN_IN-1:0]   a2,
    input  logic signed [LEN_IN-1:0]   a3,
    input  logic signed [LEN_IN-1:0]   b0,
    input  logic signed [LEN_IN-1:0]   b1,
    input  logic signed [LEN_IN-1:0]   b2,
    input  logic signed [LEN_IN-1:0]   b3,
    output logic signed [2*LEN_IN+1:0] sum
);
    localparam int PROD_W = 2*LEN_IN;
    localparam int ROW_W  = 2*LEN_IN+2;

    logic signed [PROD_W-1:0] p0, p1, p2, p3;

    // Operands widened before multiplying so -128*-128 lands exactly at +16384.
    assign p0 = PROD_W'(a0) * PROD_W'(b0);
    assign p1 = PROD_W'(a1) * PROD_W'(b1);
    assign p2 = PROD_W'(a2) * PROD_W'(b2);
    assign p3 = PROD_W'(a3) * PROD_W'(b3);

    assign sum = ROW_W'(p0) + ROW_W'(p1) + ROW_W'(p2) + ROW_W'(p3);
endmodule

// File: rtl/conv_mac4x4.sv
// Signed 4x4 window x kernel dot product; latency 1, or 2 when CONV_PIPE2_EN
// is defined (extra register after the four row sums).
module conv_mac4x4 #(
    parameter int LEN_IN  = conv_pkg::LEN_IN,
    parameter int LEN_OUT = conv_pkg::LEN_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [LEN_IN-1:0]  data00, data01, data02, data03,
    input  logic signed [LEN_IN-1:0]  data10, data11, data12, data13,
    input  logic signed [LEN_IN-1:0]  data20, data21, data22, data23,
    input  logic signed [LEN_IN-1:0]  data30, data31, data32, data33,
    input  logic signed [LEN_IN-1:0]  kernel00, kernel01, kernel02, kernel03,
    input  logic signed [LEN_IN-1:0]  kernel10, kernel11, kernel12, kernel13,
    input  logic signed [LEN_IN-1:0]  kernel20, kernel21, kernel22, kernel23,
    input  logic signed [LEN_IN-1:0]  kernel30, kernel31, kernel32, kernel33,
    output logic signed [LEN_OUT-1:0] conv_out,
    output logic                      out_valid
);
    import conv_pkg::*;

    localparam int ROW_W = 2*LEN_IN+2;
    localparam int SUM_W = 2*LEN_IN+4;

    function automatic logic signed [LEN_OUT-1:0] widen(input logic signed [SUM_W-1:0] v);
        return LEN_OUT'(v);
    endfunction

    logic signed [LEN_IN-1:0] data   [KSIZE][KSIZE];
    logic signed [LEN_IN-1:0] kernel [KSIZE][KSIZE];
    logic signed [ROW_W-1:0]  row_sum [KSIZE];
    logic signed [ROW_W-1:0]  row_sel [KSIZE];
    logic signed [SUM_W-1:0]  total;
    logic                     stage_vld;

    assign data[0]   = '{data00, data01, data02, data03};
    assign data[1]   = '{data10, data11, data12, data13};
    assign data[2]   = '{data20, data21, data22, data23};
    assign data[3]   = '{data30, data31, data32, data33};
    assign kernel[0] = '{kernel00, kernel01, kernel02, kernel03};
    assign kernel[1] = '{kernel10, kernel11, kernel12, kernel13};
    assign kernel[2] = '{kernel20, kernel21, kernel22, kernel23};
    assign kernel[3] = '{kernel30, kernel31, kernel32, kernel33};

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        conv_dot4 #(.LEN_IN(LEN_IN)) u_dot (
            .a0 (data[r][0]),   .a1 (data[r][1]),
            .a2 (data[r][2]),   .a3 (data[r][3]),
            .b0 (kernel[r][0]), .b1 (kernel[r][1]),
            .b2 (kernel[r][2]), .b3 (kernel[r][3]),
            .sum(row_sum[r])
        );
    end

`ifdef CONV_PIPE2_EN
    logic signed [ROW_W-1:0] row_p0 [KSIZE];
    logic                    vld_p0;

    // Stage p0: row sums registered
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            for (int r = 0; r < KSIZE; r++) row_p0[r] <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                for (int r = 0; r < KSIZE; r++) row_p0[r] <= row_sum[r];
            end
        end
    end

    always_comb begin
        stage_vld = vld_p0;
        for (int r = 0; r < KSIZE; r++) row_sel[r] = row_p0[r];
    end
`else
    always_comb begin
        stage_vld = in_valid;
        for (int r = 0; r < KSIZE; r++) row_sel[r] = row_sum[r];
    end
`endif

    assign total = SUM_W'(row_sel[0]) + SUM_W'(row_sel[1])
                 + SUM_W'(row_sel[2]) + SUM_W'(row_sel[3]);

    // Stage p1: output register, held while no fresh result arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stage_vld;
            if (stage_vld) conv_out <= widen(total);
        end
    end
endmodule

// File: tb/tb_conv_mac4x4.sv
// Self-checking bench for conv_mac4x4: directed corner vectors, random streaming, reset mid-stream.
module tb_conv_mac4x4;
    import conv_pkg::*;

`ifdef CONV_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    elem_t dv [16];
    elem_t kv [16];
    acc_t  conv_out;
    logic  out_valid;

    int checks = 0;
    int passes = 0;
    bit hv [$];
    int hval [$];
    int held = 0;

    always #5 clk = ~clk;

    conv_mac4x4 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .data00(dv[0]),  .data01(dv[1]),  .data02(dv[2]),  .data03(dv[3]),
        .data10(dv[4]),  .data11(dv[5]),  .data12(dv[6]),  .data13(dv[7]),
        .data20(dv[8]),  .data21(dv[9]),  .data22(dv[10]), .data23(dv[11]),
        .data30(dv[12]), .data31(dv[13]), .data32(dv[14]), .data33(dv[15]),
        .kernel00(kv[0]),  .kernel01(kv[1]),  .kernel02(kv[2]),  .kernel03(kv[3]),
        .kernel10(kv[4]),  .kernel11(kv[5]),  .kernel12(kv[6]),  .kernel13(kv[7]),
        .kernel20(kv[8]),  .kernel21(kv[9]),  .kernel22(kv[10]), .kernel23(kv[11]),
        .kernel30(kv[12]), .kernel31(kv[13]), .kernel32(kv[14]), .kernel33(kv[15]),
        .conv_out(conv_out), .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic signed [24:0] got,
                         input logic signed [24:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One clock: model the dot product directly over 16 elements, keep a
    // per-cycle history, and expect the entry LAT-1 cycles back at the output.
    task automatic step(input bit v, input bit r, input string tag);
        int refv = 0;
        int idx;
        bit exp_v;
        for (int i = 0; i < 16; i++) refv += int'(dv[i]) * int'(kv[i]);
        in_valid = v;
        rst = r;
        hv.push_back(v && !r);
        hval.push_back(refv);
        if (r) begin
            foreach (hv[i]) hv[i] = 1'b0;
            held = 0;
        end
        @(posedge clk);
        #1;
        idx = hv.size() - LAT;
        exp_v = (idx >= 0) ? hv[idx] : 1'b0;
        if (exp_v) held = hval[idx];
        check({tag, "_valid"}, {24'd0, out_valid}, {24'd0, exp_v});
        check({tag, "_value"}, conv_out, 25'(held));
        rst = 1'b0;
    endtask

    task automatic fill(input int d, input int k);
        for (int i = 0; i < 16; i++) begin
            dv[i] = 8'(d);
            kv[i] = 8'(k);
        end
    endtask

    task automatic flush(input string tag);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        fill(0, 0);
        step(1'b0, 1'b1, "reset");
        step(1'b0, 1'b1, "reset");

        fill(1, 1);
        step(1'b1, 1'b0, "ones");
        flush("ones_flush");
        check("ones_const", conv_out, 25'sd16);

        fill(-128, -128);
        step(1'b1, 1'b0, "maxpos");
        flush("maxpos_flush");
        check("maxpos_const", conv_out, 25'sd262144);

        fill(-128, 127);
        step(1'b1, 1'b0, "minneg");
        flush("minneg_flush");
        check("minneg_const", conv_out, -25'sd260096);

        for (int i = 0; i < 16; i++) begin
            dv[i] = 8'(i + 1);
            kv[i] = (i % 5 == 0) ? 8'sd1 : 8'sd0;
        end
        step(1'b1, 1'b0, "diag");
        flush("diag_flush");
        check("diag_const", conv_out, 25'sd34);

        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 16; i++) begin
                dv[i] = 8'($urandom);
                kv[i] = 8'($urandom);
            end
            step(1'b1, 1'b0, "rand");
        end
        for (int i = 0; i < 16; i++) dv[i] = 8'($urandom);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, "hold");

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) begin
                dv[i] = 8'($urandom);
                kv[i] = 8'($urandom);
            end
            step(1'b1, 1'b0, "pre_rst");
        end
        step(1'b1, 1'b1, "mid_rst");
        check("mid_rst_zero", conv_out, 25'sd0);
        for (int i = 0; i < 16; i++) begin
            dv[i] = 8'($urandom);
            kv[i] = 8'($urandom);
        end
        step(1'b1, 1'b0, "post_rst");
        flush("post_rst_flush");
        step(1'b0, 1'b0, "idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
